acq_sequencer: RTL and testbench

- Sequences one acquisition through the stream packetizer: programs its packet-length register over an AXI4-Lite manager port, gates the ADC sample stream for a requested number of packets, then disables the packetizer and reports completion.
- Sits between the ADC manager stream output and the packetizer stream input, with its AXI4-Lite manager write channel on the packetizer's configuration port.

---
 rtl/acq_pkg.sv | 25 ++
 rtl/axil_single_write.sv | 89 ++++++++
 rtl/acq_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_acq_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition sequencer and its AXI4-Lite write helper.
package acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG_WR,
    ST_CFG_RESP,
    ST_RUN,
    ST_DIS_WR,
    ST_DIS_RESP,
    ST_DONE
  } acq_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Packetizer register map (byte addresses)
  localparam logic [31:0] PKT_CFG_ADDR    = 32'h0000_001C;
  localparam logic [31:0] PKT_STATUS_ADDR = 32'h0000_0024;

  localparam int unsigned AXIL_AW  = 32;
  localparam int unsigned AXIL_DW  = 32;
  localparam int unsigned STREAM_W = 32;

endpackage

// File: rtl/axil_single_write.sv
// One-shot AXI4-Lite write manager: req launches aw/w together, each channel
// retires on its own ready, then bready is held until the response arrives.
module axil_single_write
  import acq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic               cancel,
  input  logic [AXIL_AW-1:0] addr,
  input  logic [AXIL_DW-1:0] data,
  output logic [AXIL_AW-1:0] awaddr,
  output logic [2:0]         awprot,
  output logic               awvalid,
  input  logic               awready,
  output logic [AXIL_DW-1:0] wdata,
  output logic [3:0]         wstrb,
  output logic               wvalid,
  input  logic               wready,
  input  logic [1:0]         bresp,
  input  logic               bvalid,
  output logic               bready,
  output logic               accept_c,
  output logic               done_c,
  output logic [1:0]         resp_c
);

  logic               aw_pend_q, aw_pend_d;
  logic               w_pend_q, w_pend_d;
  logic               bready_q, bready_d;
  logic [AXIL_AW-1:0] addr_q, addr_d;
  logic [AXIL_DW-1:0] data_q, data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      bready_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      bready_q  <= bready_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    bready_d  = bready_q;
    addr_d    = addr_q;
    data_d    = data_q;
    accept_c  = 1'b0;
    if (req) begin
      aw_pend_d = 1'b1;
      w_pend_d  = 1'b1;
      bready_d  = 1'b0;
      addr_d    = addr;
      data_d    = data;
    end else if (cancel) begin
      aw_pend_d = 1'b0;
      w_pend_d  = 1'b0;
      bready_d  = 1'b0;
    end else begin
      if (aw_pend_q && awready) aw_pend_d = 1'b0;
      if (w_pend_q && wready)   w_pend_d  = 1'b0;
      // Both channels retired (possibly on different cycles): open the response phase
      if ((aw_pend_q || w_pend_q) && !aw_pend_d && !w_pend_d) begin
        accept_c = 1'b1;
        bready_d = 1'b1;
      end
      if (bready_q && bvalid) bready_d = 1'b0;
    end
  end

  assign awaddr  = addr_q;
  assign awprot  = 3'b000;
  assign awvalid = aw_pend_q;
  assign wdata   = data_q;
  assign wstrb   = 4'hF;
  assign wvalid  = w_pend_q;
  assign bready  = bready_q;
  assign done_c  = bready_q & bvalid;
  assign resp_c  = bresp;

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: programs the packetizer length, gates the ADC stream for N packets,
// then disables the packetizer. Optional watchdog: define ACQ_SEQUENCER_WATCHDOG_EN.
module acq_sequencer
  import acq_pkg::*;
#(
  parameter logic [31:0] CFG_ADDR    = PKT_CFG_ADDR,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned WDOG_CYCLES = 1_000_000
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                start,
  input  logic                abort,
  input  logic [31:0]         packet_len,
  input  logic [CNT_W-1:0]    num_packets,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                aborted,
  output logic [CNT_W-1:0]    pkt_count,
  output logic [31:0]         m_axi_lite_awaddr,
  output logic [2:0]          m_axi_lite_awprot,
  output logic                m_axi_lite_awvalid,
  input  logic                m_axi_lite_awready,
  output logic [31:0]         m_axi_lite_wdata,
  output logic [3:0]          m_axi_lite_wstrb,
  output logic                m_axi_lite_wvalid,
  input  logic                m_axi_lite_wready,
  input  logic [1:0]          m_axi_lite_bresp,
  input  logic                m_axi_lite_bvalid,
  output logic                m_axi_lite_bready,
  input  logic [STREAM_W-1:0] s_axis_data_tdata,
  input  logic                s_axis_data_tvalid,
  output logic                s_axis_data_tready,
  output logic [STREAM_W-1:0] m_axis_data_tdata,
  output logic                m_axis_data_tvalid,
  input  logic                m_axis_data_tready,
  input  logic                last
);

  acq_state_e       state_q, state_d;
  logic             gate_q, gate_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             aborted_q, aborted_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;
  logic [CNT_W-1:0] num_q, num_d;

  logic             wr_req_c, wr_cancel_c, wr_accept_c, wr_done_c;
  logic [1:0]       wr_resp_c;
  logic [31:0]      wr_data_c;
  logic             pkt_done_c, final_c;

  assign m_axis_data_tvalid = s_axis_data_tvalid & gate_q;
  assign s_axis_data_tready = m_axis_data_tready & gate_q;
  assign m_axis_data_tdata  = s_axis_data_tdata;
  assign pkt_done_c         = last & m_axis_data_tvalid & m_axis_data_tready;

`ifdef ACQ_SEQUENCER_WATCHDOG_EN
  localparam int unsigned WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              wdog_hit_c;
  assign wdog_hit_c = (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) wdog_q <= '0;
    else          wdog_q <= wdog_d;
  end
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      gate_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      aborted_q <= 1'b0;
      pkt_q     <= '0;
      num_q     <= '0;
    end else begin
      state_q   <= state_d;
      gate_q    <= gate_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      aborted_q <= aborted_d;
      pkt_q     <= pkt_d;
      num_q     <= num_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    error_d     = error_q;
    aborted_d   = aborted_q;
    pkt_d       = pkt_q;
    num_d       = num_q;
    wr_req_c    = 1'b0;
    wr_cancel_c = 1'b0;
    wr_data_c   = 32'h0;
    final_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_d     = num_packets;
          pkt_d     = '0;
          error_d   = 1'b0;
          aborted_d = 1'b0;
          if (packet_len == 32'h0) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            wr_req_c  = 1'b1;
            wr_data_c = packet_len;
            state_d   = ST_CFG_WR;
          end
        end
      end
      ST_CFG_WR:   if (wr_accept_c) state_d = ST_CFG_RESP;
      ST_CFG_RESP: begin
        if (wr_done_c) begin
          if (wr_resp_c == RESP_OKAY) begin
            state_d = ST_RUN;
          end else begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (pkt_done_c) begin
          if (pkt_q != '1) pkt_d = pkt_q + CNT_W'(1);
          final_c = (num_q != '0) && ((pkt_q + CNT_W'(1)) == num_q);
        end
        // The final completion takes precedence over a coincident abort
        if (final_c) begin
          wr_req_c = 1'b1;
          state_d  = ST_DIS_WR;
        end else if (abort) begin
          aborted_d = 1'b1;
          wr_req_c  = 1'b1;
          state_d   = ST_DIS_WR;
        end
      end
      ST_DIS_WR:   if (wr_accept_c) state_d = ST_DIS_RESP;
      ST_DIS_RESP: begin
        if (wr_done_c) begin
          if (wr_resp_c != RESP_OKAY) error_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

`ifdef ACQ_SEQUENCER_WATCHDOG_EN
    if (wdog_hit_c) begin
      if (state_q == ST_RUN && state_d == ST_RUN) begin
        aborted_d = 1'b1;
        error_d   = 1'b1;
        wr_req_c  = 1'b1;
        state_d   = ST_DIS_WR;
      end else if (state_q inside {ST_CFG_WR, ST_CFG_RESP, ST_DIS_WR, ST_DIS_RESP}) begin
        error_d     = 1'b1;
        wr_cancel_c = 1'b1;
        state_d     = ST_DONE;
      end
    end
    // Restart on every state entry; in RUN any stream handshake also restarts it
    wdog_d = '0;
    if (state_d == state_q) begin
      if (state_q inside {ST_CFG_WR, ST_CFG_RESP, ST_DIS_WR, ST_DIS_RESP}) begin
        wdog_d = wdog_q + WDOG_W'(1);
      end else if (state_q == ST_RUN && !(m_axis_data_tvalid && m_axis_data_tready)) begin
        wdog_d = wdog_q + WDOG_W'(1);
      end
    end
`endif

    gate_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  axil_single_write u_wr (
    .clk      (aclk),
    .rst_n    (aresetn),
    .req      (wr_req_c),
    .cancel   (wr_cancel_c),
    .addr     (CFG_ADDR),
    .data     (wr_data_c),
    .awaddr   (m_axi_lite_awaddr),
    .awprot   (m_axi_lite_awprot),
    .awvalid  (m_axi_lite_awvalid),
    .awready  (m_axi_lite_awready),
    .wdata    (m_axi_lite_wdata),
    .wstrb    (m_axi_lite_wstrb),
    .wvalid   (m_axi_lite_wvalid),
    .wready   (m_axi_lite_wready),
    .bresp    (m_axi_lite_bresp),
    .bvalid   (m_axi_lite_bvalid),
    .bready   (m_axi_lite_bready),
    .accept_c (wr_accept_c),
    .done_c   (wr_done_c),
    .resp_c   (wr_resp_c)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign aborted   = aborted_q;
  assign pkt_count = pkt_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Scoreboard bench for acq_sequencer: an AXI4-Lite responder and a packetizer/stream model
// check every write and every passed beat against queued expectations.
module tb_acq_sequencer;

  logic        aclk, aresetn, start, abort;
  logic [31:0] packet_len;
  logic [15:0] num_packets;
  logic        busy, done, error, aborted;
  logic [15:0] pkt_count;
  logic [31:0] awaddr, wdata, s_tdata, m_tdata;
  logic [2:0]  awprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        s_tvalid, s_tready, m_tvalid, m_tready, last;

  int          checks, errors;
  int          beats_seen, early_beats, wr_count, bhs_count, bhs_base;
  int          aw_delay, w_delay;
  logic [1:0]  b_code;
  logic [31:0] beat_idx, plen_model;
  logic [31:0] q_beat[$];
  logic [63:0] q_wr[$];

  acq_sequencer dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort),
    .packet_len(packet_len), .num_packets(num_packets),
    .busy(busy), .done(done), .error(error), .aborted(aborted), .pkt_count(pkt_count),
    .m_axi_lite_awaddr(awaddr), .m_axi_lite_awprot(awprot), .m_axi_lite_awvalid(awvalid),
    .m_axi_lite_awready(awready), .m_axi_lite_wdata(wdata), .m_axi_lite_wstrb(wstrb),
    .m_axi_lite_wvalid(wvalid), .m_axi_lite_wready(wready), .m_axi_lite_bresp(bresp),
    .m_axi_lite_bvalid(bvalid), .m_axi_lite_bready(bready),
    .s_axis_data_tdata(s_tdata), .s_axis_data_tvalid(s_tvalid), .s_axis_data_tready(s_tready),
    .m_axis_data_tdata(m_tdata), .m_axis_data_tvalid(m_tvalid), .m_axis_data_tready(m_tready),
    .last(last)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Packetizer model: tlast on the final beat of each packet_len+1 beat packet
  assign last = (beat_idx == plen_model);

  task automatic axi_slave();
    bit          aw_got, w_got, b_clear;
    int          aw_wait, w_wait;
    logic [31:0] cap_addr, cap_data;
    logic [2:0]  cap_prot;
    logic [3:0]  cap_strb;
    logic [63:0] exp;
    aw_got = 0; w_got = 0; b_clear = 0; aw_wait = 0; w_wait = 0;
    forever begin
      @(negedge aclk);
      awready = 1'b0;
      wready  = 1'b0;
      if (b_clear) begin
        bvalid  = 1'b0;
        b_clear = 0;
      end else if (aw_got && w_got && !bvalid) begin
        bvalid = 1'b1;
        bresp  = b_code;
        aw_got = 0;
        w_got  = 0;
        wr_count++;
        checks++;
        if (q_wr.size() == 0) begin
          errors++;
          $display("FAIL axi_unexpected_write got addr=%08h data=%08h expected none", cap_addr, cap_data);
        end else begin
          exp = q_wr.pop_front();
          if ({cap_addr, cap_data} !== exp) begin
            errors++;
            $display("FAIL axi_write got addr=%08h data=%08h expected addr=%08h data=%08h",
                     cap_addr, cap_data, exp[63:32], exp[31:0]);
          end
        end
        checks++;
        if (cap_prot !== 3'b000 || cap_strb !== 4'hF) begin
          errors++;
          $display("FAIL axi_prot_strb got prot=%0h strb=%0h expected prot=0 strb=f", cap_prot, cap_strb);
        end
      end
      if (awvalid && !aw_got) begin
        if (aw_wait >= aw_delay) begin
          awready = 1'b1; aw_got = 1; aw_wait = 0;
          cap_addr = awaddr; cap_prot = awprot;
        end else aw_wait++;
      end
      if (wvalid && !w_got) begin
        if (w_wait >= w_delay) begin
          wready = 1'b1; w_got = 1; w_wait = 0;
          cap_data = wdata; cap_strb = wstrb;
        end else w_wait++;
      end
      if (bvalid && bready) begin
        b_clear = 1;
        bhs_count++;
      end
    end
  endtask

  task automatic stream_monitor();
    bit          hs;
    logic [31:0] exp;
    forever begin
      @(negedge aclk);
      hs = m_tvalid && m_tready;
      if (hs) begin
        beats_seen++;
        if (bhs_count == bhs_base) early_beats++;
        checks++;
        if (q_beat.size() == 0) begin
          errors++;
          $display("FAIL beat_extra got=%08h expected no beat", m_tdata);
        end else begin
          exp = q_beat.pop_front();
          if (m_tdata !== exp) begin
            errors++;
            $display("FAIL beat_data got=%08h expected=%08h", m_tdata, exp);
          end
        end
      end
      @(posedge aclk);
      #1;
      if (hs) begin
        s_tdata  = s_tdata + 32'd1;
        beat_idx = (beat_idx == plen_model) ? 32'd0 : beat_idx + 32'd1;
      end
    end
  endtask

  task automatic prepare(input logic [31:0] plen);
    plen_model  = plen;
    beat_idx    = 32'd0;
    beats_seen  = 0;
    early_beats = 0;
    wr_count    = 0;
    bhs_base    = bhs_count;
  endtask

  task automatic pulse_start(input logic [31:0] plen, input logic [15:0] npk);
    @(posedge aclk); #1;
    packet_len  = plen;
    num_packets = npk;
    start       = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit got);
    got = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge aclk);
      if (done) begin
        got = 1;
        break;
      end
    end
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 200 && beats_seen < n; i++) begin
      @(negedge aclk); #1;
    end
    checks++;
    if (beats_seen < n) begin
      errors++;
      $display("FAIL beat_wait_timeout got=%0d expected=%0d", beats_seen, n);
    end
  endtask

  task automatic check_end(input string name, input bit got, input logic exp_err,
                           input logic exp_abt, input logic [15:0] exp_pkt,
                           input int exp_beats, input int exp_wr);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_done_timeout got no done expected done", name);
    end
    checks++;
    if (error !== exp_err || aborted !== exp_abt || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_status got err=%b abt=%b busy=%b expected err=%b abt=%b busy=0",
               name, error, aborted, busy, exp_err, exp_abt);
    end
    checks++;
    if (pkt_count !== exp_pkt) begin
      errors++;
      $display("FAIL %s_pkt_count got=%0d expected=%0d", name, pkt_count, exp_pkt);
    end
    checks++;
    if (beats_seen != exp_beats || wr_count != exp_wr || q_wr.size() != 0 || q_beat.size() != 0) begin
      errors++;
      $display("FAIL %s_traffic got beats=%0d writes=%0d left_wr=%0d left_beats=%0d expected beats=%0d writes=%0d",
               name, beats_seen, wr_count, q_wr.size(), q_beat.size(), exp_beats, exp_wr);
    end
    @(negedge aclk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse got done=%b expected 0", name, done);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 0 || done !== 0 || error !== 0 || aborted !== 0 || pkt_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_status got busy=%b done=%b err=%b abt=%b pkt=%0d expected all 0",
               busy, done, error, aborted, pkt_count);
    end
    checks++;
    if (awvalid !== 0 || wvalid !== 0 || bready !== 0) begin
      errors++;
      $display("FAIL reset_axi got awv=%b wv=%b br=%b expected 0", awvalid, wvalid, bready);
    end
    checks++;
    if (m_tvalid !== 0 || s_tready !== 0) begin
      errors++;
      $display("FAIL reset_gate got m_tvalid=%b s_tready=%b expected 0", m_tvalid, s_tready);
    end
  endtask

  task automatic run_basic(input string name, input int awd, input int wd, input bit poke_start);
    bit got;
    aw_delay = awd;
    w_delay  = wd;
    prepare(32'd3);
    q_wr.push_back({32'h0000_001C, 32'd3});
    q_wr.push_back({32'h0000_001C, 32'd0});
    for (int i = 0; i < 8; i++) q_beat.push_back(s_tdata + 32'(i));
    pulse_start(32'd3, 16'd2);
    if (poke_start) begin
      wait_beats(2);
      pulse_start(32'd0, 16'd5);
    end
    wait_done(300, got);
    check_end(name, got, 1'b0, 1'b0, 16'd2, 8, 2);
    checks++;
    if (early_beats != 0) begin
      errors++;
      $display("FAIL %s_early_beats got=%0d expected=0", name, early_beats);
    end
  endtask

  task automatic test_basic();        run_basic("basic", 0, 0, 1'b0); endtask
  task automatic test_delayed_ready(); run_basic("delayed", 5, 2, 1'b0); endtask
  task automatic test_start_ignored(); run_basic("start_busy", 1, 0, 1'b1); endtask

  task automatic test_cfg_error();
    bit got;
    aw_delay = 0;
    w_delay  = 0;
    b_code   = 2'b10;
    prepare(32'd3);
    q_wr.push_back({32'h0000_001C, 32'd3});
    pulse_start(32'd3, 16'd2);
    wait_done(100, got);
    check_end("cfg_err", got, 1'b1, 1'b0, 16'd0, 0, 1);
    b_code = 2'b00;
  endtask

  task automatic test_abort();
    bit got;
    prepare(32'd1);
    q_wr.push_back({32'h0000_001C, 32'd1});
    q_wr.push_back({32'h0000_001C, 32'd0});
    for (int i = 0; i < 5; i++) q_beat.push_back(s_tdata + 32'(i));
    pulse_start(32'd1, 16'd0);
    wait_beats(4);
    @(posedge aclk); #1;
    abort = 1'b1;
    @(posedge aclk); #1;
    abort = 1'b0;
    wait_done(100, got);
    check_end("abort", got, 1'b0, 1'b1, 16'd2, 5, 2);
  endtask

  task automatic test_zero_len();
    bit got;
    prepare(32'd0);
    pulse_start(32'd0, 16'd4);
    wait_done(2, got);
    check_end("zero_len", got, 1'b1, 1'b0, 16'd0, 0, 0);
  endtask

  task automatic test_reset_midrun();
    prepare(32'd3);
    q_wr.push_back({32'h0000_001C, 32'd3});
    for (int i = 0; i < 40; i++) q_beat.push_back(s_tdata + 32'(i));
    pulse_start(32'd3, 16'd0);
    wait_beats(3);
    @(posedge aclk); #1;
    aresetn = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 0 || s_tready !== 0) begin
      errors++;
      $display("FAIL midrun_reset_gate got m_tvalid=%b s_tready=%b expected 0", m_tvalid, s_tready);
    end
    checks++;
    if (busy !== 0 || pkt_count !== 16'd0 || awvalid !== 0 || error !== 0) begin
      errors++;
      $display("FAIL midrun_reset_outputs got busy=%b pkt=%0d awv=%b err=%b expected 0",
               busy, pkt_count, awvalid, error);
    end
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    q_beat.delete();
    q_wr.delete();
    repeat (3) @(negedge aclk);
    checks++;
    if (busy !== 0 || awvalid !== 0 || m_tvalid !== 0) begin
      errors++;
      $display("FAIL midrun_reset_idle got busy=%b awv=%b m_tvalid=%b expected 0", busy, awvalid, m_tvalid);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    beats_seen = 0; early_beats = 0; wr_count = 0; bhs_count = 0; bhs_base = 0;
    aw_delay = 0; w_delay = 0; b_code = 2'b00;
    beat_idx = 32'd0; plen_model = 32'd0;
    aresetn = 1'b0; start = 1'b0; abort = 1'b0;
    packet_len = 32'd0; num_packets = 16'd0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    s_tdata = 32'hA000_0000; s_tvalid = 1'b1; m_tready = 1'b1;
    fork
      axi_slave();
      stream_monitor();
    join_none
    repeat (3) @(posedge aclk);
    #1;
    test_reset();
    aresetn = 1'b1;
    @(negedge aclk);
    test_reset();
    test_basic();
    test_delayed_ready();
    test_cfg_error();
    test_abort();
    test_zero_len();
    test_start_ignored();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
